// File: rtl/performance_event_select.sv
`default_nettype none
// ============================================================================
// Module   : performance_event_select
// Purpose  : Routes selected raw event strobes onto per-counter pulse outputs
//            with level/edge qualification and an optional prescaler
//            (enabled by defining PERF_EVENT_PRESCALE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module performance_event_select #(
  parameter int          NUM_SOURCES  = 64,
  parameter int          NUM_SLOTS    = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] raw_events,
  output logic [NUM_SLOTS-1:0]   perf_events,
  input  logic [31:0]            io_address,
  input  logic                   io_write_en,
  input  logic [31:0]            io_write_data,
  input  logic                   io_read_en,
  output logic [31:0]            io_read_data
);

  localparam int          c_IDX_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [31:0] c_CTRL_OFFSET = 32'(4 * NUM_SLOTS);
  localparam logic [31:0] c_NUM_SOURCES = 32'(NUM_SOURCES);

  logic [NUM_SOURCES-1:0]        r_raw_q;
  logic [NUM_SOURCES-1:0]        r_raw_qq;
  logic [255:0]                  w_raw_q_pad;
  logic [255:0]                  w_raw_qq_pad;
  logic                          r_freeze;
  logic [NUM_SLOTS-1:0]          r_perf_events;
  logic [31:0]                   r_read_data;
  logic [31:0]                   w_offset;
  logic                          w_slot_hit;
  logic                          w_ctrl_hit;
  logic [c_IDX_W-1:0]            w_slot_idx;
  logic [NUM_SLOTS-1:0][31:0]    w_cfg_rd;
  logic [NUM_SLOTS-1:0]          w_pulse;
  logic [31:0]                   w_read_mux;
  logic                          w_unused_wdata;

  assign w_offset   = io_address - BASE_ADDRESS;
  assign w_slot_hit = (w_offset[1:0] == 2'b00) && (w_offset < c_CTRL_OFFSET);
  assign w_ctrl_hit = (w_offset == c_CTRL_OFFSET);
  assign w_slot_idx = w_offset[c_IDX_W+1:2];

  // Zero-extend to the full 8-bit src range so any src value indexes safely.
  assign w_raw_q_pad  = 256'(r_raw_q);
  assign w_raw_qq_pad = 256'(r_raw_qq);

  assign w_unused_wdata = ^io_write_data[31:10];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_raw_q  <= '0;
      r_raw_qq <= '0;
    end else begin
      r_raw_q  <= raw_events;
      r_raw_qq <= r_raw_q;
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [7:0] r_src;
    logic       r_en;
    logic       r_edge_mode;
    logic [3:0] w_shift;
    logic       w_wr;
    logic       w_src_valid;
    logic       w_qual;
    logic       w_fire;

    assign w_wr = io_write_en && w_slot_hit && (w_slot_idx == c_IDX_W'(gi));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_src       <= 8'd0;
        r_en        <= 1'b0;
        r_edge_mode <= 1'b0;
      end else if (w_wr) begin
        r_src       <= io_write_data[7:0];
        r_en        <= io_write_data[8];
        r_edge_mode <= io_write_data[9];
      end
    end

    assign w_src_valid = ({24'd0, r_src} < c_NUM_SOURCES);
    // Edge history comes from the shared per-source pipeline, so retargeting
    // src never fabricates an edge.
    assign w_qual = r_en && w_src_valid && !r_freeze && w_raw_q_pad[r_src] &&
                    !(r_edge_mode && w_raw_qq_pad[r_src]);

`ifdef PERF_EVENT_PRESCALE_EN
    logic [3:0]  r_shift;
    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic [15:0] w_mask;

    assign w_count_next = r_count + 16'd1;
    assign w_mask       = (16'd1 << r_shift) - 16'd1;
    assign w_fire       = ((w_count_next & w_mask) == 16'd0);
    assign w_shift      = r_shift;

    // A config write restarts the count even if this cycle also qualifies.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_shift <= 4'd0;
        r_count <= 16'd0;
      end else if (w_wr) begin
        r_shift <= io_write_data[15:12];
        r_count <= 16'd0;
      end else if (w_qual) begin
        r_count <= w_count_next;
      end
    end
`else
    assign w_fire  = 1'b1;
    assign w_shift = 4'd0;
`endif

    assign w_pulse[gi]  = w_qual && w_fire;
    assign w_cfg_rd[gi] = {16'd0, w_shift, 2'b00, r_edge_mode, r_en, r_src};
  end

  always_comb begin
    w_read_mux = 32'd0;
    if (w_slot_hit) begin
      w_read_mux = w_cfg_rd[w_slot_idx];
    end else if (w_ctrl_hit) begin
      w_read_mux = {31'd0, r_freeze};
    end
  end

  // Reads sample state before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_freeze      <= 1'b0;
      r_perf_events <= '0;
      r_read_data   <= 32'd0;
    end else begin
      if (io_write_en && w_ctrl_hit) begin
        r_freeze <= io_write_data[0];
      end
      r_perf_events <= w_pulse;
      if (io_read_en) begin
        r_read_data <= w_read_mux;
      end
    end
  end

  assign perf_events  = r_perf_events;
  assign io_read_data = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_performance_event_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_performance_event_select
// Purpose  : Directed, self-checking bench for performance_event_select.
// Revision : 1.0 - initial release
// ============================================================================
module tb_performance_event_select;

  localparam int          NUM_SOURCES = 64;
  localparam int          NUM_SLOTS   = 8;
  localparam logic [31:0] BASE        = 32'h0;
  localparam logic [31:0] CTRL        = BASE + 32'(4 * NUM_SLOTS);
  localparam int          MAXC        = 2048;
`ifdef PERF_EVENT_PRESCALE_EN
  localparam logic [31:0] RES_EXP = 32'h0000_F3FF;
`else
  localparam logic [31:0] RES_EXP = 32'h0000_03FF;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_SOURCES-1:0] raw_events;
  logic [NUM_SLOTS-1:0]   perf_events;
  logic [31:0]            io_address;
  logic                   io_write_en;
  logic [31:0]            io_write_data;
  logic                   io_read_en;
  logic [31:0]            io_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  performance_event_select #(
    .NUM_SOURCES (NUM_SOURCES),
    .NUM_SLOTS   (NUM_SLOTS),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_events   (raw_events),
    .perf_events  (perf_events),
    .io_address   (io_address),
    .io_write_en  (io_write_en),
    .io_write_data(io_write_data),
    .io_read_en   (io_read_en),
    .io_read_data (io_read_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: per-cycle history tables -------------
  typedef struct packed {
    logic [7:0] src;
    logic       en;
    logic       edg;
    logic [3:0] shift;
  } cfg_t;

  cfg_t                   m_cfg    [NUM_SLOTS];
  logic                   m_freeze = 1'b0;
  cfg_t                   snap     [MAXC][NUM_SLOTS];
  logic                   frz_snap [MAXC];
  logic [NUM_SOURCES-1:0] raw_hist [MAXC];
  logic                   rst_hist [MAXC];
  logic [NUM_SLOTS-1:0]   wr_hist  [MAXC];
  int                     m_cnt    [NUM_SLOTS];
  int                     cyc = 0;

  // Record what the DUT saw in cycle cyc and the config in force for cyc+1.
  always @(posedge clk) begin
    logic [31:0] off;
    if (cyc < MAXC - 1) begin
      raw_hist[cyc] = raw_events;
      rst_hist[cyc] = reset;
      wr_hist[cyc]  = '0;
      off = io_address - BASE;
      if (reset) begin
        for (int s = 0; s < NUM_SLOTS; s++) m_cfg[s] = '0;
        m_freeze = 1'b0;
      end else if (io_write_en) begin
        if (off[1:0] == 2'b00 && off < 32'(4 * NUM_SLOTS)) begin
          m_cfg[off / 4].src = io_write_data[7:0];
          m_cfg[off / 4].en  = io_write_data[8];
          m_cfg[off / 4].edg = io_write_data[9];
`ifdef PERF_EVENT_PRESCALE_EN
          m_cfg[off / 4].shift = io_write_data[15:12];
`else
          m_cfg[off / 4].shift = 4'd0;
`endif
          wr_hist[cyc][off / 4] = 1'b1;
        end else if (off == 32'(4 * NUM_SLOTS)) begin
          m_freeze = io_write_data[0];
        end
      end
      cyc++;
      for (int s = 0; s < NUM_SLOTS; s++) snap[cyc][s] = m_cfg[s];
      frz_snap[cyc] = m_freeze;
    end
  end

  // Output in cycle t follows from raw events in t-2/t-3 and config of t-1.
  always @(negedge clk) begin
    logic [NUM_SLOTS-1:0] exp_ev;
    logic rq, rqq, q;
    cfg_t c;
    int   t;
    t = cyc;
    if (t >= 3 && t < MAXC - 1) begin
      exp_ev = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        c   = snap[t-1][s];
        rq  = 1'b0;
        rqq = 1'b0;
        if (int'(c.src) < NUM_SOURCES) begin
          rq  = rst_hist[t-2] ? 1'b0 : raw_hist[t-2][c.src];
          rqq = rst_hist[t-3] ? 1'b0 : raw_hist[t-3][c.src];
        end
        q = !rst_hist[t-1] && c.en && (int'(c.src) < NUM_SOURCES) &&
            !frz_snap[t-1] && rq && (!c.edg || !rqq);
        if (rst_hist[t-1]) begin
          m_cnt[s] = 0;
        end else begin
          if (q) begin
            m_cnt[s] = (m_cnt[s] + 1) % 65536;
            q = ((m_cnt[s] % (1 << c.shift)) == 0);
          end
          if (wr_hist[t-1][s]) m_cnt[s] = 0;
        end
        exp_ev[s] = q;
      end
      n_tests++;
      if (perf_events !== exp_ev) begin
        n_fail++;
        $display("FAIL model_perf_events cycle %0d: got %b expected %b", t, perf_events, exp_ev);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations -------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    io_address    = a;
    io_write_data = d;
    io_write_en   = 1'b1;
    tick();
    io_write_en   = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    io_address = a;
    io_read_en = 1'b1;
    tick();
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  obs;
    logic [15:0] obs16;
    logic        others;
    int          cnt;

    for (int s = 0; s < NUM_SLOTS; s++) m_cnt[s] = 0;
    reset = 1'b1; raw_events = '0;
    io_address = '0; io_write_en = 1'b0; io_write_data = '0; io_read_en = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    for (int s = 0; s < NUM_SLOTS; s++) begin
      io_read(BASE + 32'(4 * s), rd);
      check("reset_slot_read", rd, 32'h0);
    end
    io_read(CTRL, rd);
    check("reset_ctrl_read", rd, 32'h0);
    check("reset_perf", 32'(perf_events), 32'h0);

    // Level routing on slot 0
    io_write(BASE, 32'h105);
    io_read(BASE, rd);
    check("slot0_readback", rd, 32'h105);
    obs = '0; others = 1'b0;
    for (int k = 0; k < 8; k++) begin
      raw_events[5] = (k < 3);
      obs[k] = perf_events[0];
      others |= |perf_events[NUM_SLOTS-1:1];
      tick();
    end
    check("level_pulses", 32'(obs), 32'h1C);
    check("level_other_slots", 32'(others), 32'h0);

    // Edge routing on slot 1
    io_write(BASE + 32'd4, 32'h30A);
    obs = '0;
    for (int k = 0; k < 8; k++) begin
      raw_events[10] = (k < 4);
      obs[k] = perf_events[1];
      tick();
    end
    check("edge_single_pulse", 32'(obs), 32'h04);

    // Source index out of range never fires
    io_write(BASE + 32'd8, 32'h100 | 32'(NUM_SOURCES));
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      raw_events = (k < 5) ? '1 : '0;
      cnt += int'(perf_events[2]);
      tick();
    end
    check("src_out_of_range", 32'(cnt), 32'h0);

    // Reserved bits and unmapped addresses
    io_write(BASE + 32'd16, 32'hFFFF_FFFF);
    io_read(BASE + 32'd16, rd);
    check("reserved_bits", rd, RES_EXP);
    io_write(CTRL + 32'd4, 32'hFFFF_FFFF);
    io_read(CTRL + 32'd4, rd);
    check("unmapped_read", rd, 32'h0);
    io_read(CTRL, rd);
    check("ctrl_untouched", rd, 32'h0);
    io_read(BASE + 32'd1, rd);
    check("misaligned_read", rd, 32'h0);

    // Freeze and resume
    raw_events[5] = 1'b1;
    repeat (3) tick();
    io_write(CTRL, 32'h1);
    check("freeze_plus1", 32'(perf_events[0]), 32'h1);
    tick();
    check("freeze_plus2", 32'(perf_events), 32'h0);
    repeat (3) tick();
    check("freeze_hold", 32'(perf_events), 32'h0);
    io_read(CTRL, rd);
    check("freeze_read", rd, 32'h1);
    io_write(CTRL, 32'h0);
    check("unfreeze_plus1", 32'(perf_events[0]), 32'h0);
    tick();
    check("unfreeze_resume", 32'(perf_events[0]), 32'h1);

    // Simultaneous read and write to the same slot
    io_address = BASE; io_write_data = 32'h10A;
    io_write_en = 1'b1; io_read_en = 1'b1;
    tick();
    io_write_en = 1'b0; io_read_en = 1'b0;
    check("rw_same_cycle_old", io_read_data, 32'h105);
    io_read(BASE, rd);
    check("rw_new_value", rd, 32'h10A);
    io_write(BASE, 32'h105);
    tick();
    check("read_data_hold", io_read_data, 32'h10A);

`ifdef PERF_EVENT_PRESCALE_EN
    // Prescaler: one pulse per four qualifying cycles
    raw_events[5] = 1'b0;
    io_write(BASE + 32'd12, 32'h2107);
    obs16 = '0;
    for (int k = 0; k < 16; k++) begin
      raw_events[7] = (k < 8);
      obs16[k] = perf_events[3];
      tick();
    end
    check("prescale_pulses", 32'(obs16), 32'h0220);
    // Rewriting the config mid-stream restarts the count
    raw_events[7] = 1'b1;
    repeat (2) tick();
    io_write(BASE + 32'd12, 32'h2107);
    obs = '0;
    for (int k = 0; k < 8; k++) begin
      obs[k] = perf_events[3];
      tick();
    end
    check("prescale_restart", 32'(obs), 32'h10);
    raw_events[7] = 1'b0;
`else
    obs16 = '0;
    check("prescale_absent_shift", 32'(obs16), 32'h0);
`endif

    // Reset with pulses in flight
    raw_events[5] = 1'b1;
    repeat (3) tick();
    check("pre_reset_pulse", 32'(perf_events[0]), 32'h1);
    reset = 1'b1;
    tick();
    check("reset_flush", 32'(perf_events), 32'h0);
    reset = 1'b0;
    tick();
    io_read(BASE, rd);
    check("reset_cfg_cleared", rd, 32'h0);
    check("post_reset_quiet", 32'(perf_events), 32'h0);
    raw_events = '0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/performance_event_select.md
# performance_event_select

Programmable event router that sits directly upstream of the performance counter block. It samples a wide bus of raw single-cycle event strobes from the core and caches, and routes software-selected sources onto a narrow `perf_events` bus. Each slot has its own configuration register on the IO bus: source select, enable, and level or rising-edge qualification, plus an optional prescaler. Each output bit drives exactly one counter.

## Interface
Parameters:
- NUM_SOURCES, 64: width of the raw event bus; at most 256.
- NUM_SLOTS, 8: number of routed outputs; equals the downstream counter count.
- BASE_ADDRESS, 0: byte address of slot 0's configuration register.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- raw_events  in  NUM_SOURCES  raw event strobes, one bit per source.
- perf_events  out  NUM_SLOTS  routed event pulses, one bit per slot.
- io_address  in  32  IO bus byte address.
- io_write_en  in  1  IO write strobe.
- io_write_data  in  32  IO write data.
- io_read_en  in  1  IO read strobe.
- io_read_data  out  32  IO read data, registered.

## Operation
- Register map:
  - Slot i config is at BASE_ADDRESS + 4*i.
  - Global control is at BASE_ADDRESS + 4*NUM_SLOTS.
  - Any other address reads 0 and ignores writes.
- Slot config fields:
  - [7:0] src: source index.
  - [8] en: slot enable.
  - [9] edge: 1 = rising-edge mode, 0 = level mode.
  - [15:12] shift: prescale exponent; implemented only with the macro.
  - All other bits are reserved: they read 0 and writes to them are ignored.
- Global control: bit [0] is freeze. All other bits read 0.
- Pipeline stages:
  - Stage 1 registers the whole raw_events bus into raw_q.
  - raw_qq holds the previous value of raw_q, so edge history is kept per source, not per slot.
- Qualification per slot, using the slot's src:
  - Level mode: qualify = raw_q[src].
  - Edge mode: qualify = raw_q[src] & ~raw_qq[src].
  - qualify is forced to 0 when any of the following holds: en = 0, src >= NUM_SOURCES, or freeze = 1.
- Stage 2 registers the per-slot result into perf_events. Every pulse lasts exactly one cycle per qualifying cycle.
- Level mode counts cycles: a source held high for K cycles yields K pulses.
- A config write takes effect on the cycle after the write. Changing src does not create a spurious edge, because edge history is per source.
- Freeze:
  - perf_events is 0 while freeze is set.
  - raw_q and raw_qq keep updating.
  - Prescaler counts hold.
- Reset clears raw_q, raw_qq, perf_events, io_read_data, all slot configs and freeze. Reset asserted mid-stream drops any in-flight pulse; perf_events is 0 on the next cycle.
- If io_write_en and io_read_en both target the same address in the same cycle, the read returns the pre-write value.

## Timing
- Raw-to-output latency is 2 cycles: a raw event high in cycle N gives perf_events high in cycle N+2.
- Edge mode: first high cycle N gives a single pulse in cycle N+2, provided the source was low in cycle N-1.
- IO read latency is 1 cycle: io_read_en in cycle N gives io_read_data valid in cycle N+1. io_read_data holds its last value when io_read_en is low.
- A write in cycle N changes qualification from cycle N+1, so outputs change from cycle N+2.
- There are no stalls and no backpressure; the downstream counters accept one pulse per slot per cycle.

## Configuration
- Macro: PERF_EVENT_PRESCALE_EN.
- With the macro defined:
  - Each slot has a 16-bit prescale counter.
  - Each qualifying cycle increments the counter.
  - A pulse is emitted when the low `shift` bits of the counter wrap to 0, i.e. one pulse per 2^shift qualifying events. shift = 0 is pass-through.
  - The 16-bit counter wraps modulo 2^16.
  - Writing the slot's config clears its counter.
  - shift values above 15 cannot occur, because the field is 4 bits.
- Without the macro:
  - No prescale counters are built.
  - The shift field reads 0 and writes to it are ignored.
  - Behaviour is identical to shift = 0.

## Test plan
- Reset, then read every slot and the control register -> all read 0 and perf_events = 0.
- Level routing: slot 0 config = 0x105 (src 5, en, level); raw_events[5] high for 3 cycles starting at N -> perf_events[0] high in cycles N+2 through N+4. Other slots stay 0.
- Edge routing: slot 1 config = 0x30A (src 10, en, edge); raw_events[10] high for 4 cycles -> exactly one pulse on perf_events[1], 2 cycles after the first high cycle.
- Boundaries:
  - Slot 2 config with src = NUM_SOURCES -> no pulses for any raw_events stimulus.
  - Write freeze = 1 -> all outputs 0 from 2 cycles after the write.
  - Clear freeze -> level-mode output resumes.
- Prescaler, only with PERF_EVENT_PRESCALE_EN: slot 3 config = 0x2107 (src 7, en, level, shift 2); raw_events[7] high for 8 cycles -> exactly 2 pulses, spaced 4 cycles apart. Rewriting the config mid-stream restarts the count.
- IO corner cases:
  - Read and write to slot 0 in the same cycle -> old value returned.
  - Reset asserted while pulses are in flight -> perf_events = 0 the next cycle and the configs read 0.
